// File: rtl/uart_cmd_assembler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared types and constants for the UART command assembler.
//               Holds the FSM state encoding, the command width, the default
//               gap-timer configuration and the checksum helper.
//               Optional checksum protocol is selected by CMD_CHKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        WAIT_HI  = 2'd0,
        WAIT_LO  = 2'd1,
        WAIT_CHK = 2'd2
    } state_t;

    localparam int CMD_W          = 16;
    localparam int DEF_TO_CYCLES  = 130000;
    localparam int DEF_TO_W       = 18;

    // Check byte expected after {hi, lo}: inverted XOR, so an all-zero
    // frame never carries an all-zero check byte.
    function automatic logic [7:0] chk8(input logic [7:0] hi, input logic [7:0] lo);
        return ~(hi ^ lo);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_cmd_assembler_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_assembler_if
// Description : Handshake bundle between the UART receiver / command consumer
//               and the command assembler.
//               rx_rdy, rx_data     : receiver byte-ready level and byte
//               clr_rx_rdy          : one-cycle acknowledge back to receiver
//               cmd, cmd_rdy        : assembled command and valid level
//               clr_cmd_rdy         : consumer acknowledge
//               ovr, timeout, chk_err : status (sticky / pulse / pulse)
//               Modport slave is the assembler; master is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_cmd_assembler_if;
    import uart_cmd_pkg::*;

    logic             rx_rdy;
    logic [7:0]       rx_data;
    logic             clr_rx_rdy;
    logic [CMD_W-1:0] cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic             ovr;
    logic             timeout;
    logic             chk_err;

    modport master (
        output rx_rdy, rx_data, clr_cmd_rdy,
        input  clr_rx_rdy, cmd, cmd_rdy, ovr, timeout, chk_err
    );

    modport slave (
        input  rx_rdy, rx_data, clr_cmd_rdy,
        output clr_rx_rdy, cmd, cmd_rdy, ovr, timeout, chk_err
    );

endinterface
`default_nettype wire

// File: rtl/uart_cmd_assembler_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : uart_gap_timer
// Description : Loadable down-counter measuring the gap between bytes.
//               clk, rst_n : clock, synchronous active-low reset
//               load       : reload count with TO_CYCLES (has priority)
//               en         : count down while high; count clears while low
//               expired    : high when count==1 and en=1
// Revision    : 1.0 - initial release
// ============================================================================
module uart_gap_timer #(
    parameter int TO_CYCLES = 130000,
    parameter int TO_W      = 18
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic load,
    input  wire logic en,
    output logic      expired
);

    localparam logic [TO_W-1:0] C_LOAD = TO_W'(TO_CYCLES);
    localparam logic [TO_W-1:0] C_ONE  = TO_W'(1);

    logic [TO_W-1:0] r_count;

    // Clearing whenever disabled keeps the count at zero outside the
    // byte-wait states, so it never wraps and never carries stale time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= C_LOAD;
        end else if (en) begin
            if (r_count != '0) begin
                r_count <= r_count - C_ONE;
            end
        end else begin
            r_count <= '0;
        end
    end

    assign expired = en && (r_count == C_ONE);

endmodule
`default_nettype wire

// File: rtl/uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_assembler
// Description : Collects a 2-byte command (high byte first) from the UART
//               receiver into a 16-bit word, acknowledging each byte, with an
//               inter-byte gap timeout that resynchronises framing.
//               clk, rst_n : clock, synchronous active-low reset
//               bus        : uart_cmd_assembler_if.slave handshake bundle
//               Optional macro CMD_CHKSUM_EN adds a third check byte that
//               must equal ~(hi ^ lo).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_assembler
    import uart_cmd_pkg::*;
#(
    parameter int TO_CYCLES = DEF_TO_CYCLES,
    parameter int TO_W      = DEF_TO_W
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    uart_cmd_assembler_if.slave   bus
);

    state_t           r_state;
    logic [7:0]       r_hi;
`ifdef CMD_CHKSUM_EN
    logic [7:0]       r_lo;
`endif
    logic [CMD_W-1:0] r_cmd;
    logic             r_cmd_rdy;
    logic             r_ovr;
    logic             r_timeout;
    logic             r_chk_err;

    logic             w_accept;
    logic             w_load;
    logic             w_en;
    logic             w_expired;
    logic             w_complete;
    logic [CMD_W-1:0] w_cmd_next;

    // Every state is a byte-wait state, so any ready byte is taken at once.
    // The FSM leaves the state on that edge, so each byte is taken once.
    assign w_accept = rst_n && bus.rx_rdy;

    // Reload only when another byte of the same command is still expected.
`ifdef CMD_CHKSUM_EN
    assign w_load = w_accept && (r_state != WAIT_CHK);
`else
    assign w_load = w_accept && (r_state == WAIT_HI);
`endif

    // Disabling on an accepted byte lets the final byte clear the count.
    assign w_en = (r_state != WAIT_HI) && !bus.rx_rdy;

`ifdef CMD_CHKSUM_EN
    assign w_complete = w_accept && (r_state == WAIT_CHK) &&
                        (bus.rx_data == chk8(r_hi, r_lo));
    assign w_cmd_next = {r_hi, r_lo};
`else
    assign w_complete = w_accept && (r_state == WAIT_LO);
    assign w_cmd_next = {r_hi, bus.rx_data};
`endif

    uart_gap_timer #(
        .TO_CYCLES (TO_CYCLES),
        .TO_W      (TO_W)
    ) u_gap_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (w_load),
        .en      (w_en),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= WAIT_HI;
            r_hi      <= '0;
`ifdef CMD_CHKSUM_EN
            r_lo      <= '0;
`endif
            r_cmd     <= '0;
            r_cmd_rdy <= 1'b0;
            r_ovr     <= 1'b0;
            r_timeout <= 1'b0;
            r_chk_err <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            r_chk_err <= 1'b0;

            case (r_state)
                WAIT_HI: begin
                    if (w_accept) begin
                        r_hi    <= bus.rx_data;
                        r_state <= WAIT_LO;
                    end
                end
                WAIT_LO: begin
                    if (w_accept) begin
`ifdef CMD_CHKSUM_EN
                        r_lo    <= bus.rx_data;
                        r_state <= WAIT_CHK;
`else
                        r_state <= WAIT_HI;
`endif
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_hi      <= '0;
                        r_state   <= WAIT_HI;
                    end
                end
`ifdef CMD_CHKSUM_EN
                WAIT_CHK: begin
                    if (w_accept) begin
                        if (!w_complete) begin
                            r_chk_err <= 1'b1;
                        end
                        r_state <= WAIT_HI;
                    end else if (w_expired) begin
                        r_timeout <= 1'b1;
                        r_hi      <= '0;
                        r_state   <= WAIT_HI;
                    end
                end
`endif
                default: begin
                    r_state <= WAIT_HI;
                end
            endcase

            // A completing command beats a same-cycle consumer clear; ovr
            // only latches when an unread command is actually overwritten.
            if (w_complete) begin
                r_cmd     <= w_cmd_next;
                r_cmd_rdy <= 1'b1;
                if (r_cmd_rdy && !bus.clr_cmd_rdy) begin
                    r_ovr <= 1'b1;
                end
            end else if (bus.clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
                r_ovr     <= 1'b0;
            end
        end
    end

    assign bus.clr_rx_rdy = w_accept;
    assign bus.cmd        = r_cmd;
    assign bus.cmd_rdy    = r_cmd_rdy;
    assign bus.ovr        = r_ovr;
    assign bus.timeout    = r_timeout;
    assign bus.chk_err    = r_chk_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_assembler
// Description : Directed self-checking bench for uart_cmd_assembler with a
//               short gap limit (TO_CYCLES=20). Honours CMD_CHKSUM_EN by
//               appending the check byte to each command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_assembler;
    import uart_cmd_pkg::*;

    localparam int C_TO = 20;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    uart_cmd_assembler_if bus ();

    uart_cmd_assembler #(
        .TO_CYCLES (C_TO),
        .TO_W      (18)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total  = 0;
    int bad    = 0;
    int n_sent = 0;
    int n_clr  = 0;
    int n_to   = 0;
    int n_chk  = 0;

    // Pulse counters, sampled on the active edge before any DUT update.
    always @(posedge clk) begin
        if (bus.clr_rx_rdy) n_clr <= n_clr + 1;
        if (bus.timeout)    n_to  <= n_to + 1;
        if (bus.chk_err)    n_chk <= n_chk + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one byte as the receiver would; it is accepted on the next
    // rising edge and rdy is withdrawn just after that edge.
    task automatic send_byte(input logic [7:0] b, input logic with_clr);
        @(negedge clk);
        bus.rx_rdy      = 1'b1;
        bus.rx_data     = b;
        bus.clr_cmd_rdy = with_clr;
        @(posedge clk);
        #1;
        bus.rx_rdy      = 1'b0;
        bus.clr_cmd_rdy = 1'b0;
        n_sent++;
    endtask

    task automatic send_cmd(input logic [7:0] hi, input logic [7:0] lo, input logic last_clr);
        send_byte(hi, 1'b0);
        idle(2);
`ifdef CMD_CHKSUM_EN
        send_byte(lo, 1'b0);
        idle(2);
        send_byte(chk8(hi, lo), last_clr);
`else
        send_byte(lo, last_clr);
`endif
    endtask

    task automatic clear_cmd();
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b1;
        @(posedge clk);
        #1;
        bus.clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.rx_rdy      = 1'b0;
        bus.rx_data     = 8'h00;
        bus.clr_cmd_rdy = 1'b0;
        idle(3);

        // Reset state; a ready byte during reset must not be acknowledged.
        bus.rx_rdy = 1'b1;
        #1;
        check("clr_in_reset", {31'd0, bus.clr_rx_rdy}, 32'd0);
        bus.rx_rdy = 1'b0;
        check("rst_cmd",     {16'd0, bus.cmd}, 32'h0000);
        check("rst_cmd_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        check("rst_ovr",     {31'd0, bus.ovr}, 32'd0);
        check("rst_timeout", {31'd0, bus.timeout}, 32'd0);
        check("rst_chk_err", {31'd0, bus.chk_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Basic command with idle gaps.
        send_byte(8'hA5, 1'b0);
        check("hi_no_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        idle(3);
`ifdef CMD_CHKSUM_EN
        send_byte(8'h3C, 1'b0);
        idle(3);
        send_byte(8'h66, 1'b0);
`else
        send_byte(8'h3C, 1'b0);
`endif
        check("a53c_cmd", {16'd0, bus.cmd}, 32'hA53C);
        check("a53c_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        check("a53c_ovr", {31'd0, bus.ovr}, 32'd0);
        check("clr_per_byte_1", n_clr, n_sent);

        // Overrun, then consumer clear drops both flags.
        send_cmd(8'h12, 8'h34, 1'b0);
        check("ovr_cmd", {16'd0, bus.cmd}, 32'h1234);
        check("ovr_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        check("ovr_set", {31'd0, bus.ovr}, 32'd1);
        clear_cmd();
        check("clr_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        check("clr_ovr", {31'd0, bus.ovr}, 32'd0);

        // Gap timeout: pulse lands exactly TO cycles after the hi byte.
        send_byte(8'h55, 1'b0);
        idle(C_TO - 1);
        check("to_early_pulse", {31'd0, bus.timeout}, 32'd0);
        check("to_early_cnt", n_to, 0);
        idle(1);
        check("to_pulse", {31'd0, bus.timeout}, 32'd1);
        idle(1);
        check("to_one_pulse", {31'd0, bus.timeout}, 32'd0);
        check("to_count", n_to, 1);
        check("to_no_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        check("to_cmd_kept", {16'd0, bus.cmd}, 32'h1234);
        send_cmd(8'h01, 8'h02, 1'b0);
        check("resync_cmd", {16'd0, bus.cmd}, 32'h0102);
        check("resync_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        check("resync_ovr", {31'd0, bus.ovr}, 32'd0);
        clear_cmd();

        // Low byte arrives in the very cycle the timer would expire.
        send_byte(8'hD0, 1'b0);
        idle(C_TO - 1);
        send_byte(8'hE0, 1'b0);
`ifdef CMD_CHKSUM_EN
        send_byte(chk8(8'hD0, 8'hE0), 1'b0);
`endif
        check("edge_cmd", {16'd0, bus.cmd}, 32'hD0E0);
        check("edge_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        idle(1);
        check("edge_no_to", n_to, 1);

        // Set overrun, then completion coincident with consumer clear.
        send_cmd(8'h0A, 8'h0B, 1'b0);
        check("ovr2_set", {31'd0, bus.ovr}, 32'd1);
        send_cmd(8'hC1, 8'hC2, 1'b1);
        check("same_cmd", {16'd0, bus.cmd}, 32'hC1C2);
        check("same_rdy", {31'd0, bus.cmd_rdy}, 32'd1);
        check("same_ovr", {31'd0, bus.ovr}, 32'd1);
        clear_cmd();
        check("same_clr_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        check("same_clr_ovr", {31'd0, bus.ovr}, 32'd0);

        // Reset after a hi byte must discard it.
        send_byte(8'h66, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("mid_rst_cmd", {16'd0, bus.cmd}, 32'h0000);
        check("mid_rst_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        idle(2);
        send_cmd(8'h77, 8'h88, 1'b0);
        check("after_rst_cmd", {16'd0, bus.cmd}, 32'h7788);
        check("after_rst_ovr", {31'd0, bus.ovr}, 32'd0);

`ifdef CMD_CHKSUM_EN
        // Bad check byte: pulse chk_err, command outputs untouched.
        clear_cmd();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h00, 1'b0);
        check("chk_pulse", {31'd0, bus.chk_err}, 32'd1);
        check("chk_no_rdy", {31'd0, bus.cmd_rdy}, 32'd0);
        check("chk_cmd_kept", {16'd0, bus.cmd}, 32'h7788);
        idle(1);
        check("chk_count", n_chk, 1);
`else
        idle(1);
        check("chk_tied_off", n_chk, 0);
`endif

        check("clr_per_byte_all", n_clr, n_sent);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_assembler.md
Name: uart_cmd_assembler

Overview:
Sequences the byte-wide UART receiver, which exposes rx_data[7:0], rdy and clr_rdy. It collects a 2-byte command, high byte first, into a 16-bit cmd word for the command processor, and acknowledges each byte back to the receiver. An inter-byte gap timer resynchronises framing if a byte is lost. Sits between the UART receiver and the command-processing FSM; this is the single owner of the receiver's clr_rdy.

Parameters:
TO_CYCLES, 130000, inter-byte gap limit in clk cycles (about 5 byte times at 19200 baud / 50 MHz); legal range 2 to 2^TO_W-1.
TO_W, 18, width of the gap timer.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
rx_rdy  input  1  receiver byte-ready flag (level, held until cleared)
rx_data  input  8  receiver byte, valid while rx_rdy=1
clr_rx_rdy  output  1  one-cycle acknowledge to the receiver's clr_rdy
cmd  output  16  assembled command {hi, lo}
cmd_rdy  output  1  command-valid flag, level
clr_cmd_rdy  input  1  consumer acknowledge
ovr  output  1  sticky overrun flag
timeout  output  1  one-cycle pulse when a partial command is discarded
chk_err  output  1  one-cycle pulse on checksum mismatch (0 without CMD_CHKSUM_EN)

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values: state=WAIT_HI, cmd=16'h0000, cmd_rdy=0, ovr=0, timer=0, hi byte register=0, clr_rx_rdy=0, timeout=0, chk_err=0.
- Reset mid-command discards any held hi byte. Reset does not reach the receiver.
- clr_rx_rdy is combinational: asserted in exactly the cycle the FSM accepts a byte (rx_rdy=1 in a WAIT_* state), otherwise 0.
  - The receiver drops rdy one cycle later.
  - The FSM has moved state by then, so each byte is accepted exactly once.
- WAIT_HI:
  - On rx_rdy: hi <= rx_data; timer <= TO_CYCLES; go to WAIT_LO.
- WAIT_LO:
  - Timer decrements by 1 per cycle.
  - On rx_rdy: complete the command with lo=rx_data (see "Completion"); go to WAIT_HI.
  - Else, when timer==1: pulse timeout, discard hi, go to WAIT_HI.
  - rx_rdy in the same cycle as timer==1: the byte wins, no timeout.
- Completion (registered, latency 1):
  - cmd <= {hi, lo} and cmd_rdy <= 1 on the clock edge that accepts the final byte, so they are visible the next cycle.
- cmd_rdy clearing:
  - clr_cmd_rdy clears cmd_rdy.
  - Completion and clr_cmd_rdy in the same cycle: set wins.
- Overrun:
  - Completion while cmd_rdy=1 and clr_cmd_rdy=0 overwrites cmd, keeps cmd_rdy=1 and sets ovr.
  - ovr is cleared only by clr_cmd_rdy when no completion occurs in that same cycle.
- Timer never wraps: it holds at 0 in WAIT_HI and is reloaded on each accepted byte.

Optional Feature:
CMD_CHKSUM_EN
- Defined: a third byte is required.
  - After the lo byte the FSM goes to WAIT_CHK and reloads the timer.
  - On rx_rdy, if rx_data == ~(hi ^ lo), complete the command as above.
  - On mismatch, pulse chk_err, leave cmd/cmd_rdy/ovr unchanged, return to WAIT_HI.
  - A timeout in WAIT_CHK behaves as in WAIT_LO.
- Undefined: 2-byte protocol; the WAIT_CHK state does not exist; chk_err tied 0.

Decomposition:
- Package uart_cmd_pkg:
  - state enum {WAIT_HI, WAIT_LO, WAIT_CHK}
  - CMD_W=16
  - default TO_CYCLES/TO_W constants
  - checksum function chk8(hi, lo)
- Sub-module uart_gap_timer:
  - Loadable down-counter: ports clk, rst_n, load, en, expired.
  - expired is high when count==1 and en=1.

Test Plan:
- Reset, then bytes 8'hA5, 8'h3C with idle gaps -> exactly one clr_rx_rdy per byte; cmd=16'hA53C and cmd_rdy=1 one cycle after the second accept; ovr=0.
- With cmd_rdy=1 and no clr_cmd_rdy, send 8'h12, 8'h34 -> cmd=16'h1234, cmd_rdy=1, ovr=1. Then pulse clr_cmd_rdy -> cmd_rdy=0 and ovr=0 next cycle.
- Send 8'h55, then wait TO_CYCLES with no byte (TO_CYCLES=20 for sim) -> timeout pulses once, cmd_rdy stays 0. Then send 8'h01, 8'h02 -> cmd=16'h0102.
- Drive clr_cmd_rdy in the same cycle as the final-byte accept while cmd_rdy=1 -> cmd_rdy remains 1 and ovr=1.
- Assert rst_n=0 for one cycle after the hi byte, then send 8'h77, 8'h88 -> cmd=16'h7788, proving the held hi byte was discarded.
- CMD_CHKSUM_EN: bytes 8'hA5, 8'h3C, 8'h66 (~(A5^3C)) -> cmd=16'hA53C, cmd_rdy=1. Bytes 8'hA5, 8'h3C, 8'h00 -> chk_err pulse, cmd_rdy stays 0.
